// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared defaults, FSM state encoding and requester ids for the
//               two-port SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

   localparam int c_ADDR_W = 11;
   localparam int c_DATA_W = 64;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Requester identifiers, also used as the last-grantee pointer
   typedef enum logic [0:0] {
      HOST = 1'b0,
      CAL  = 1'b1
   } req_id_t;

   // 4-bit increment that sticks at 15
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hf) ? v : v + 4'd1;
   endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_stat.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_stat
// Description : Saturating 16-bit count of contested cycles with a clear
//               input that loads 1 when a clear and a conflict coincide.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_stat
   import sram_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        conflict,
   input  logic        clr,
   output logic [15:0] cnt
);

   localparam logic [15:0] c_CNT_MAX = 16'hffff;

   logic [15:0] r_cnt;

   // Clear wins over hold, but a coincident conflict is still counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 16'h0000;
      end else if (clr) begin
         r_cnt <= conflict ? 16'h0001 : 16'h0000;
      end else if (conflict && (r_cnt != c_CNT_MAX)) begin
         r_cnt <= r_cnt + 16'h0001;
      end
   end

   assign cnt = r_cnt;

endmodule : sram_arb_stat
`default_nettype wire

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb
// Description : Arbitrates a single-port SRAM between a host and a calc
//               engine. Grants are combinational, read data returns one
//               cycle later; the calc engine may lock the port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arb
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arb_mode,
   input  logic [3:0]        starve_max,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvld,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              cal_req,
   input  logic              cal_we,
   input  logic              cal_lock,
   input  logic [ADDR_W-1:0] cal_addr,
   input  logic [DATA_W-1:0] cal_wdata,
   output logic              cal_gnt,
   output logic              cal_rvld,
   output logic [DATA_W-1:0] cal_rdata,
   output logic              inner_sram_we_n,
   output logic [ADDR_W-1:0] inner_sram_waddr,
   output logic [DATA_W-1:0] inner_sram_wdata,
   output logic              inner_sram_rd_n,
   output logic [ADDR_W-1:0] inner_sram_raddr,
   input  logic [DATA_W-1:0] inner_sram_rdata,
   output logic [15:0]       conflict_cnt,
   input  logic              conflict_cnt_rd
);

   arb_state_t r_state;
   req_id_t    r_last;
   logic [3:0] r_starve_cnt;
   logic       r_host_rvld;
   logic       r_cal_rvld;

   logic       w_contest;
   logic       w_locked;
   logic       w_host_win;
   logic       w_cal_win;

   assign w_contest = host_req & cal_req;

   // Lock only holds while cal_lock stays high; the cycle it drops the
   // arbiter already behaves as ARB, so the host can win that same cycle.
   assign w_locked  = (r_state == LOCKED) && cal_lock;

   // Winner selection
   always_comb begin
      w_host_win = 1'b0;
      w_cal_win  = 1'b0;
      if (w_locked) begin
         w_cal_win = cal_req;
      end else if (w_contest) begin
         if (!arb_mode) begin
            w_host_win = (starve_max != 4'd0) && (r_starve_cnt >= starve_max);
         end else begin
            w_host_win = (r_last == CAL);
         end
         w_cal_win = ~w_host_win;
      end else begin
         w_host_win = host_req;
         w_cal_win  = cal_req;
      end
   end

   // Grants are forced low while reset is asserted
   assign host_gnt = w_host_win & rst_n;
   assign cal_gnt  = w_cal_win & rst_n;

   // SRAM control mux; idle values when nothing is granted
   always_comb begin
      inner_sram_we_n  = 1'b1;
      inner_sram_waddr = '0;
      inner_sram_wdata = '0;
      inner_sram_rd_n  = 1'b1;
      inner_sram_raddr = '0;
      if (host_gnt) begin
         if (host_we) begin
            inner_sram_we_n  = 1'b0;
            inner_sram_waddr = host_addr;
            inner_sram_wdata = host_wdata;
         end else begin
            inner_sram_rd_n  = 1'b0;
            inner_sram_raddr = host_addr;
         end
      end else if (cal_gnt) begin
         if (cal_we) begin
            inner_sram_we_n  = 1'b0;
            inner_sram_waddr = cal_addr;
            inner_sram_wdata = cal_wdata;
         end else begin
            inner_sram_rd_n  = 1'b0;
            inner_sram_raddr = cal_addr;
         end
      end
   end

   // FSM with last-grantee pointer and host starvation counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ARB;
         r_last       <= CAL;
         r_starve_cnt <= 4'd0;
      end else begin
         case (r_state)
            ARB:     if (cal_gnt && cal_lock) r_state <= LOCKED;
            LOCKED:  if (!cal_lock)           r_state <= ARB;
            default:                          r_state <= ARB;
         endcase

         if (host_gnt) begin
            r_last <= HOST;
         end else if (cal_gnt) begin
            r_last <= CAL;
         end

         if (host_gnt) begin
            r_starve_cnt <= 4'd0;
         end else if (!w_locked && w_contest) begin
            r_starve_cnt <= sat_inc4(r_starve_cnt);
         end
      end
   end

   // Read-valid pipeline, one cycle behind the read grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_host_rvld <= 1'b0;
         r_cal_rvld  <= 1'b0;
      end else begin
         r_host_rvld <= host_gnt & ~host_we;
         r_cal_rvld  <= cal_gnt & ~cal_we;
      end
   end

   assign host_rvld  = r_host_rvld;
   assign cal_rvld   = r_cal_rvld;
   assign host_rdata = r_host_rvld ? inner_sram_rdata : '0;
   assign cal_rdata  = r_cal_rvld  ? inner_sram_rdata : '0;

   sram_arb_stat u_stat (
      .clk      (clk),
      .rst_n    (rst_n),
      .conflict (w_contest),
      .clr      (conflict_cnt_rd),
      .cnt      (conflict_cnt)
   );

endmodule : sram_port_arb
`default_nettype wire
